upif_bridge: RTL and testbench
==============================

# upif_bridge

Processor-bus front end for the configuration register bank. It synchronises an external asynchronous chip-select bus into the core clock domain and decodes the address into one-hot register enables. It drives write data and a single-cycle write strobe to the per-register config/status cells, and captures their OR-combined read data for return to the processor. It sits directly upstream of every `upen`/`upws`/`updi`/`updo` register cell.

## Interface
- `AW`, 8, address width
- `DW`, 8, data width
- `NREG`, 16, number of decoded register enables (must be ≤ 2^AW)
- `clk`  in  1  core clock
- `rst_`  in  1  reset, asynchronous, active-low
- `pcs_`  in  1  processor chip select, active-low, asynchronous to `clk`
- `prnw`  in  1  1 = read, 0 = write; stable while `pcs_` low
- `paddr`  in  AW  processor address; stable while `pcs_` low
- `pdi`  in  DW  processor write data; stable while `pcs_` low
- `pdo`  out  DW  processor read data, held until next read completes
- `prdy`  out  1  access complete; processor may release `pcs_`
- `perr`  out  1  last access addressed ≥ NREG; valid while `prdy`=1
- `upen`  out  NREG  one-hot register enable, one cycle per access
- `upws`  out  1  write strobe, coincident with `upen` on writes
- `updi`  out  DW  write data to register cells
- `updo`  in  DW  OR of all register cells' read data (combinational from `upen`)

## Operation
- `pcs_` passes a 2-flop synchroniser (reset value 1). `cs_s` is the second flop.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - When `cs_s`=0, register `paddr`→`adr_q`, `pdi`→`updi`, `prnw`→`rd_q`.
  - Set `perr_q` = (`paddr` ≥ NREG).
  - Go to ACCESS.
- ACCESS, exactly one cycle:
  - `upen[adr_q]`=1 if `perr_q`=0; otherwise all zero.
  - `upws` = ~`rd_q` & ~`perr_q`.
  - On a read, at the end of this cycle `pdo` ← `updo`, or 0 if `perr_q`.
  - On a write, `pdo` is unchanged.
  - Go to ACK.
- ACK:
  - `prdy`=1 and `perr`=`perr_q`.
  - Remain until `cs_s`=1, then go to IDLE with `prdy`=0.
- Only one access per `pcs_` low period. Holding `pcs_` low never repeats `upen`.
- `pcs_` pulses too short to be seen by the synchroniser are ignored.
- A `pcs_` release that is seen only in ACCESS still completes the access (ACCESS always lasts one cycle). FSM then goes ACK→IDLE on the next cycle.
- `upen` and `upws` are registered outputs, glitch-free, and decoded from `adr_q`, never from `paddr`.
- `updi` holds its last write value in IDLE. It only changes on an IDLE→ACCESS transition.
- Reset, including mid-access:
  - All outputs go to 0 immediately: `upen`, `upws`, `updi`, `pdo`, `prdy`, `perr`.
  - FSM goes to IDLE and the synchroniser goes to 1.
  - No write strobe is issued after reset is released unless a fresh `pcs_` fall is synchronised. A `pcs_` still low at reset release counts as a fresh access.

## Timing
- `pcs_` sampled low at edge 0: `cs_s`=0 after edge 1, address/data latched at edge 2.
- `upen`/`upws` high in cycle 2–3. Register cells write at edge 3.
- `pdo` valid and `prdy`=1 from edge 3.
- Release latency: `pcs_` high sampled at edge N gives `prdy`=0 after edge N+2.
- Throughput: one access per `pcs_` cycle; minimum 5 clk per access including release.
- Processor contract:
  - Hold `prnw`/`paddr`/`pdi` stable from `pcs_` fall until `prdy`=1.
  - Sample `pdo` while `prdy`=1.

## Test plan
- Write `paddr`=3, `pdi`=0xA5, `pcs_` low 8 clk → `upen`=0x0008 for exactly 1 clk with `upws`=1 and `updi`=0xA5; `prdy` rises 3 clk after the sampled `pcs_` fall and falls 2 clk after release.
- Read `paddr`=3 with cell returning 0xA5 while enabled → `upen`=0x0008, `upws`=0, `pdo`=0xA5 with `prdy`=1; `pdo` still 0xA5 after a subsequent write to address 5.
- Out of range: `paddr`=0x20, write 0xFF → `upen`=0 and `upws`=0 throughout, `perr`=1 with `prdy`; a read of 0x20 returns `pdo`=0.
- `pcs_` held low 100 clk on a write → exactly one `upen` pulse; `prdy` stays 1 until release.
- 1-clk `pcs_` low glitch placed between edges (not captured) → no `upen`; a glitch that is captured produces one full access.
- Assert `rst_` during ACCESS of a write → `upen`, `upws`, `prdy`, `pdo`, `updi` go to 0 asynchronously; after release with `pcs_` high, no strobe occurs for 10 clk.

Source files
------------

// File: rtl/upif_bridge_if.sv
// Processor-side bus of the config register bank front end.
// master = processor, slave = upif_bridge.
interface upif_bridge_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          pcs_;
    logic          prnw;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pdi;
    logic [DW-1:0] pdo;
    logic          prdy;
    logic          perr;

    modport master (
        output pcs_, prnw, paddr, pdi,
        input  pdo, prdy, perr
    );

    modport slave (
        input  pcs_, prnw, paddr, pdi,
        output pdo, prdy, perr
    );
endinterface

// File: rtl/upif_bridge.sv
// Synchronises the asynchronous chip-select bus into clk and performs one
// one-hot register access per pcs_ low period, returning the read data.
module upif_bridge #(
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            rst_,
    upif_bridge_if.slave    bus,
    output logic [NREG-1:0] upen,
    output logic            upws,
    output logic [DW-1:0]   updi,
    input  logic [DW-1:0]   updo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ACK
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_cs_meta;
    logic            r_cs_s;
    logic            r_rd_q;
    logic            r_perr_q;
    logic [DW-1:0]   r_updi;
    logic [DW-1:0]   r_pdo;
    logic [NREG-1:0] r_upen;
    logic            r_upws;
    logic            r_prdy;
    logic            r_perr;
    logic            w_start;
    logic            w_in_range;
    logic [NREG-1:0] w_upen_nxt;
    logic            w_upws_nxt;
    logic            w_prdy_nxt;
    logic            w_perr_nxt;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cs_meta <= 1'b1;
            r_cs_s    <= 1'b1;
        end else begin
            r_cs_meta <= bus.pcs_;
            r_cs_s    <= r_cs_meta;
        end
    end

    assign w_start    = (r_state == S_IDLE) && !r_cs_s;
    assign w_in_range = ({1'b0, bus.paddr} < (AW+1)'(NREG));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!r_cs_s) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_ACK;
            S_ACK:    if (r_cs_s) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Enables are registered on the edge that latches the address, so they
    // come straight from flops for the whole ACCESS cycle.
    always_comb begin
        w_upen_nxt = '0;
        w_upws_nxt = 1'b0;
        if (w_start && w_in_range) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                w_upen_nxt[i] = (bus.paddr == AW'(i));
            end
            w_upws_nxt = ~bus.prnw;
        end
        w_prdy_nxt = (w_state_nxt == S_ACK);
        w_perr_nxt = w_prdy_nxt & r_perr_q;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_rd_q   <= 1'b0;
            r_perr_q <= 1'b0;
            r_updi   <= '0;
            r_pdo    <= '0;
            r_upen   <= '0;
            r_upws   <= 1'b0;
            r_prdy   <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            if (w_start) begin
                r_rd_q   <= bus.prnw;
                r_perr_q <= ~w_in_range;
                r_updi   <= bus.pdi;
            end
            if ((r_state == S_ACCESS) && r_rd_q) begin
                r_pdo <= r_perr_q ? '0 : updo;
            end
            r_upen <= w_upen_nxt;
            r_upws <= w_upws_nxt;
            r_prdy <= w_prdy_nxt;
            r_perr <= w_perr_nxt;
        end
    end

    assign upen     = r_upen;
    assign upws     = r_upws;
    assign updi     = r_updi;
    assign bus.pdo  = r_pdo;
    assign bus.prdy = r_prdy;
    assign bus.perr = r_perr;

endmodule

// File: tb/tb_upif_bridge.sv
// Scoreboard bench for upif_bridge: a register-bank model on the cell side,
// and a transaction-level memory model predicting strobes and read data.
module tb_upif_bridge;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int NREG = 16;

    logic            clk = 1'b0;
    logic            rst_;
    logic [NREG-1:0] upen;
    logic            upws;
    logic [DW-1:0]   updi;
    logic [DW-1:0]   updo;

    always #5 clk = ~clk;

    upif_bridge_if #(.AW(AW), .DW(DW)) bus ();

    upif_bridge #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus),
        .upen (upen),
        .upws (upws),
        .updi (updi),
        .updo (updo)
    );

    // Register cells sitting downstream of the bridge
    logic [DW-1:0] cells [NREG];

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < NREG; i++) cells[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (upws && upen[i]) cells[i] <= updi;
        end
    end

    always_comb begin
        updo = '0;
        for (int i = 0; i < NREG; i++)
            if (upen[i]) updo = updo | cells[i];
    end

    // Reference model: register contents and the last read value returned
    typedef struct {
        logic [NREG-1:0] en;
        logic            ws;
        logic [DW-1:0]   di;
    } strobe_t;

    typedef struct {
        logic [DW-1:0] dout;
        logic          err;
    } rsp_t;

    logic [DW-1:0] mem [NREG];
    logic [DW-1:0] last_rd;
    strobe_t       sq[$];
    rsp_t          rq[$];
    strobe_t       s_m;
    rsp_t          r_m;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mem[i] = '0;
        last_rd = '0;
    endtask

    task automatic expect_access(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        strobe_t s;
        rsp_t    r;
        if (int'(addr) < NREG) begin
            s.en = NREG'(1) << addr;
            s.ws = ~rd;
            s.di = data;
            sq.push_back(s);
            if (rd) last_rd = mem[addr];
            else    mem[addr] = data;
        end else if (rd) begin
            last_rd = '0;
        end
        r.dout = last_rd;
        r.err  = (int'(addr) >= NREG);
        rq.push_back(r);
    endtask

    // Monitor: every strobe and every prdy rise consumes one expectation
    logic prdy_d = 1'b0;
    always @(negedge clk) begin
        if (!rst_) begin
            prdy_d = 1'b0;
        end else begin
            if (upen !== '0 || upws) begin
                if (sq.size() == 0) begin
                    check("spurious_strobe", {15'd0, upws, upen}, 32'd0);
                end else begin
                    s_m = sq.pop_front();
                    check("upen", {16'd0, upen}, {16'd0, s_m.en});
                    check("upws", {31'd0, upws}, {31'd0, s_m.ws});
                    if (s_m.ws) check("updi", {24'd0, updi}, {24'd0, s_m.di});
                end
            end
            if (bus.prdy && !prdy_d) begin
                if (rq.size() == 0) begin
                    check("spurious_prdy", {31'd0, bus.prdy}, 32'd0);
                end else begin
                    r_m = rq.pop_front();
                    check("pdo", {24'd0, bus.pdo}, {24'd0, r_m.dout});
                    check("perr", {31'd0, bus.perr}, {31'd0, r_m.err});
                end
            end
            prdy_d = bus.prdy;
        end
    end

    task automatic do_access(input logic rd, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input int hold);
        int n;
        expect_access(rd, addr, data);
        @(negedge clk);
        bus.prnw  = rd;
        bus.paddr = addr;
        bus.pdi   = data;
        bus.pcs_  = 1'b0;
        n = 0;
        while (!bus.prdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.prdy) check("prdy_rise_timeout", {31'd0, bus.prdy}, 32'd1);
        repeat (hold) @(negedge clk);
        check("prdy_held", {31'd0, bus.prdy}, 32'd1);
        bus.pcs_ = 1'b1;
        n = 0;
        while (bus.prdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.prdy) check("prdy_fall_timeout", {31'd0, bus.prdy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_upen"}, {16'd0, upen}, 32'd0);
        check({tag, "_upws"}, {31'd0, upws}, 32'd0);
        check({tag, "_updi"}, {24'd0, updi}, 32'd0);
        check({tag, "_pdo"},  {24'd0, bus.pdo}, 32'd0);
        check({tag, "_prdy"}, {31'd0, bus.prdy}, 32'd0);
        check({tag, "_perr"}, {31'd0, bus.perr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        logic          rd;
        logic [AW-1:0] a;
        rst_      = 1'b0;
        bus.pcs_  = 1'b1;
        bus.prnw  = 1'b1;
        bus.paddr = '0;
        bus.pdi   = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);

        // Write 3 <= A5 with latency measurement, pcs_ low 8 clk
        expect_access(1'b0, 8'd3, 8'hA5);
        @(negedge clk);
        bus.prnw  = 1'b0;
        bus.paddr = 8'd3;
        bus.pdi   = 8'hA5;
        bus.pcs_  = 1'b0;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.prdy && n < 10);
        check("prdy_rise_latency", n, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.pcs_ = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.prdy && n < 10);
        check("prdy_fall_latency", n, 32'd2);
        repeat (2) @(negedge clk);

        // Read back, then a write must not disturb pdo
        do_access(1'b1, 8'd3, 8'h00, 2);
        do_access(1'b0, 8'd5, 8'h3C, 1);
        do_access(1'b1, 8'd5, 8'h00, 0);

        // Out of range
        do_access(1'b0, 8'h20, 8'hFF, 2);
        do_access(1'b1, 8'h20, 8'h11, 2);

        // Long hold: one strobe only
        do_access(1'b0, 8'd9, 8'h5A, 100);
        do_access(1'b1, 8'd9, 8'h00, 0);

        // Glitch between edges is never sampled
        @(posedge clk);
        #2 bus.pcs_ = 1'b0;
        #2 bus.pcs_ = 1'b1;
        repeat (6) @(negedge clk);
        check("glitch_ignored_prdy", {31'd0, bus.prdy}, 32'd0);

        // Glitch spanning one edge completes a full access
        expect_access(1'b0, 8'd2, 8'h77);
        @(negedge clk);
        bus.prnw  = 1'b0;
        bus.paddr = 8'd2;
        bus.pdi   = 8'h77;
        bus.pcs_  = 1'b0;
        @(negedge clk);
        bus.pcs_  = 1'b1;
        repeat (8) @(negedge clk);
        check("captured_glitch_idle", {31'd0, bus.prdy}, 32'd0);
        do_access(1'b1, 8'd2, 8'h00, 0);

        // Reset during the ACCESS cycle of a write
        expect_access(1'b0, 8'd7, 8'h42);
        @(negedge clk);
        bus.prnw  = 1'b0;
        bus.paddr = 8'd7;
        bus.pdi   = 8'h42;
        bus.pcs_  = 1'b0;
        n = 0;
        while (upen == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("reset_reached_access", {16'd0, upen}, 32'h0080);
        #1 rst_ = 1'b0;
        #1 check_all_zero("midreset");
        if (rq.size() > 0) void'(rq.pop_front());
        model_reset();
        bus.pcs_ = 1'b1;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_idle", {31'd0, bus.prdy}, 32'd0);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            rd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(NREG, 255));
            else                           a = 8'($urandom_range(0, NREG - 1));
            do_access(rd, a, 8'($urandom), int'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("strobe_queue_drained", sq.size(), 32'd0);
        check("response_queue_drained", rq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
